// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the LIFO stack core
package stack_pkg;

    localparam int STACK_WIDTH   = 16;

    localparam int ERR_OVF       = 0;
    localparam int ERR_UNF       = 1;
    localparam int ERR_REP_EMPTY = 2;
    localparam int ERR_ANY       = 3;

    // Encodings match {push, pop} so the decode is a direct cast
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b10,
        OP_POP     = 2'b01,
        OP_REPLACE = 2'b11
    } stack_op_t;

    typedef enum logic [1:0] {
        RD_HOLD  = 2'b00,
        RD_WDATA = 2'b01,
        RD_MEM   = 2'b10,
        RD_ZERO  = 2'b11
    } rd_sel_t;

endpackage

// File: rtl/lifo_stack_core_if.sv
// rtl/lifo_stack_core_if.sv - push/pop stack interface (snapshot port under STACK_SNAPSHOT_EN)
interface lifo_stack_core_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] write_data;
    logic             clear_err;
    logic [WIDTH-1:0] read_data;
    logic             empty;
    logic             full;
    logic [PTR_W-1:0] count;
    logic [3:0]       error;
`ifdef STACK_SNAPSHOT_EN
    logic [4*WIDTH-1:0] snapshot;
`endif

    modport master (
        output push, pop, write_data, clear_err,
`ifdef STACK_SNAPSHOT_EN
        input  snapshot,
`endif
        input  read_data, empty, full, count, error
    );

    modport slave (
        input  push, pop, write_data, clear_err,
`ifdef STACK_SNAPSHOT_EN
        output snapshot,
`endif
        output read_data, empty, full, count, error
    );

endinterface

// File: rtl/lifo_stack_core_ptr_ctrl.sv
// rtl/lifo_stack_core_ptr_ctrl.sv - stack_ptr_ctrl: op decode, saturating count, flags, sticky errors
module stack_ptr_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH) + 1,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear_err,
    output logic [PTR_W-1:0]  count,
`ifdef STACK_SNAPSHOT_EN
    output logic [PTR_W-1:0]  count_nxt,
`endif
    output logic              empty,
    output logic              full,
    output logic [3:0]        error,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output rd_sel_t           rd_sel,
    output logic [ADDR_W-1:0] rd_addr
);
    stack_op_t        op;
    logic [PTR_W-1:0] cnt_nxt;
    logic [2:0]       err_set;
    logic [2:0]       err_q;
    logic [2:0]       err_nxt;
    logic             err_any_q;

    assign op    = stack_op_t'({push, pop});
    assign empty = (count == '0);
    assign full  = (count == PTR_W'(DEPTH));

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = count[ADDR_W-1:0];
        rd_sel  = RD_HOLD;
        rd_addr = count[ADDR_W-1:0] - ADDR_W'(2);
        cnt_nxt = count;
        err_set = '0;
        unique case (op)
            OP_PUSH: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    cnt_nxt = count + PTR_W'(1);
                    rd_sel  = RD_WDATA;
                end else begin
                    err_set[ERR_OVF] = 1'b1;
                end
            end
            OP_POP: begin
                if (count >= PTR_W'(2)) begin
                    cnt_nxt = count - PTR_W'(1);
                    rd_sel  = RD_MEM;
                end else if (count == PTR_W'(1)) begin
                    cnt_nxt = '0;
                    rd_sel  = RD_ZERO;
                end else begin
                    err_set[ERR_UNF] = 1'b1;
                end
            end
            OP_REPLACE: begin
                wr_en  = 1'b1;
                rd_sel = RD_WDATA;
                if (empty) begin
                    wr_addr                = '0;
                    cnt_nxt                = PTR_W'(1);
                    err_set[ERR_REP_EMPTY] = 1'b1;
                end else begin
                    wr_addr = count[ADDR_W-1:0] - ADDR_W'(1);
                end
            end
            default: ;
        endcase
        // A fresh error in the clearing cycle survives the clear
        err_nxt = (clear_err ? 3'b000 : err_q) | err_set;
    end

`ifdef STACK_SNAPSHOT_EN
    assign count_nxt = cnt_nxt;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            err_q     <= '0;
            err_any_q <= 1'b0;
        end else begin
            count     <= cnt_nxt;
            err_q     <= err_nxt;
            err_any_q <= |err_nxt;
        end
    end

    assign error = {err_any_q, err_q};

endmodule

// File: rtl/lifo_stack_core.sv
// rtl/lifo_stack_core.sv - LIFO storage and registered top-of-stack; STACK_SNAPSHOT_EN adds top-four snapshot
module lifo_stack_core
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    lifo_stack_core_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  read_q;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    rd_sel_t           rd_sel;
`ifdef STACK_SNAPSHOT_EN
    logic [PTR_W-1:0]   count_nxt;
    logic [4*WIDTH-1:0] snap_q;
    logic [4*WIDTH-1:0] snap_nxt;
`endif

    stack_ptr_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W)) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.push),
        .pop       (bus.pop),
        .clear_err (bus.clear_err),
        .count     (bus.count),
`ifdef STACK_SNAPSHOT_EN
        .count_nxt (count_nxt),
`endif
        .empty     (bus.empty),
        .full      (bus.full),
        .error     (bus.error),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_sel    (rd_sel),
        .rd_addr   (rd_addr)
    );

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_q <= '0;
        end else begin
            unique case (rd_sel)
                RD_WDATA: read_q <= bus.write_data;
                RD_MEM:   read_q <= mem[rd_addr];
                RD_ZERO:  read_q <= '0;
                default:  read_q <= read_q;
            endcase
        end
    end

    assign bus.read_data = read_q;

`ifdef STACK_SNAPSHOT_EN
    // Built from post-edge state so a same-cycle write shows up immediately
    always_comb begin
        logic [ADDR_W-1:0] idx;
        snap_nxt = '0;
        idx      = '0;
        for (int i = 0; i < 4; i++) begin
            idx = count_nxt[ADDR_W-1:0] - ADDR_W'(i + 1);
            if (PTR_W'(i) < count_nxt) begin
                snap_nxt[i*WIDTH +: WIDTH] = (wr_en && idx == wr_addr) ? bus.write_data : mem[idx];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_nxt;
        end
    end

    assign bus.snapshot = snap_q;
`endif

endmodule

// File: tb/tb_lifo_stack_core.sv
// tb/tb_lifo_stack_core.sv - directed self-checking bench for lifo_stack_core
module tb_lifo_stack_core;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    lifo_stack_core_if #(.WIDTH(16), .DEPTH(8)) bus ();

    lifo_stack_core #(.WIDTH(16), .DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic do_op(input logic p, input logic po, input logic [15:0] d, input logic clr);
        bus.push = p; bus.pop = po; bus.write_data = d; bus.clear_err = clr;
        @(posedge clock);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.clear_err = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.push = 1'b0; bus.pop = 1'b0; bus.write_data = '0; bus.clear_err = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.read_data !== 16'h0000) begin bad++; $display("FAIL reset_rd got=%h exp=0000", bus.read_data); end
        total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=10", bus.empty, bus.full); end
        total++; if (bus.error !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b exp=0000", bus.error); end
        reset = 1'b0;
    endtask

    task automatic test_push_pop();
        do_op(1, 0, 16'h0005, 0);
        do_op(1, 0, 16'h0003, 0);
        total++; if (bus.read_data !== 16'h0003) begin bad++; $display("FAIL push2_rd got=%h exp=0003", bus.read_data); end
        total++; if (bus.count !== 4'd2 || bus.empty !== 1'b0) begin bad++; $display("FAIL push2_cnt got=%0d/%b exp=2/0", bus.count, bus.empty); end
        total++; if (bus.error !== 4'b0000) begin bad++; $display("FAIL push2_err got=%b exp=0000", bus.error); end
        do_op(0, 1, 16'h0000, 0);
        total++; if (bus.read_data !== 16'h0005 || bus.count !== 4'd1) begin bad++; $display("FAIL pop1 got=%h/%0d exp=0005/1", bus.read_data, bus.count); end
        do_op(0, 1, 16'h0000, 0);
        total++; if (bus.read_data !== 16'h0000 || bus.empty !== 1'b1) begin bad++; $display("FAIL pop2 got=%h/%b exp=0000/1", bus.read_data, bus.empty); end
        do_op(0, 1, 16'h0000, 0);
        total++; if (bus.error !== 4'b1010 || bus.count !== 4'd0) begin bad++; $display("FAIL underflow got=%b/%0d exp=1010/0", bus.error, bus.count); end
    endtask

    task automatic test_full_replace();
        do_op(0, 0, 16'h0000, 1);
        total++; if (bus.error !== 4'b0000) begin bad++; $display("FAIL clear_unf got=%b exp=0000", bus.error); end
        for (int i = 1; i <= 8; i++) do_op(1, 0, 16'(i), 0);
        do_op(1, 0, 16'h00FF, 0);
        total++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin bad++; $display("FAIL ovf_full got=%b/%0d exp=1/8", bus.full, bus.count); end
        total++; if (bus.read_data !== 16'h0008) begin bad++; $display("FAIL ovf_rd got=%h exp=0008", bus.read_data); end
        total++; if (bus.error !== 4'b1001) begin bad++; $display("FAIL ovf_err got=%b exp=1001", bus.error); end
        do_op(1, 1, 16'h0042, 0);
        total++; if (bus.read_data !== 16'h0042 || bus.count !== 4'd8) begin bad++; $display("FAIL rep_full got=%h/%0d exp=0042/8", bus.read_data, bus.count); end
        total++; if (bus.error !== 4'b1001) begin bad++; $display("FAIL rep_full_err got=%b exp=1001", bus.error); end
        do_op(0, 0, 16'h0000, 1);
        total++; if (bus.error !== 4'b0000) begin bad++; $display("FAIL clear_ovf got=%b exp=0000", bus.error); end
        do_op(0, 1, 16'h0000, 0);
        total++; if (bus.read_data !== 16'h0007 || bus.count !== 4'd7 || bus.full !== 1'b0) begin bad++; $display("FAIL pop_full got=%h/%0d/%b exp=0007/7/0", bus.read_data, bus.count, bus.full); end
    endtask

    task automatic test_clear_collision();
        pulse_reset();
        do_op(0, 1, 16'h0000, 1);
        total++; if (bus.error !== 4'b1010) begin bad++; $display("FAIL clr_collide got=%b exp=1010", bus.error); end
        do_op(1, 1, 16'h0055, 0);
        total++; if (bus.read_data !== 16'h0055 || bus.count !== 4'd1) begin bad++; $display("FAIL rep_empty got=%h/%0d exp=0055/1", bus.read_data, bus.count); end
        total++; if (bus.error !== 4'b1110) begin bad++; $display("FAIL rep_empty_err got=%b exp=1110", bus.error); end
    endtask

    task automatic test_async_reset();
        do_op(1, 0, 16'h0066, 0);
        do_op(1, 0, 16'h0077, 0);
        total++; if (bus.count !== 4'd3 || bus.read_data !== 16'h0077) begin bad++; $display("FAIL pre_areset got=%0d/%h exp=3/0077", bus.count, bus.read_data); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.count !== 4'd0 || bus.read_data !== 16'h0000 || bus.error !== 4'b0000) begin bad++; $display("FAIL areset got=%0d/%h/%b exp=0/0000/0000", bus.count, bus.read_data, bus.error); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_add_seq();
        pulse_reset();
        do_op(1, 0, 16'h0003, 0);
        do_op(1, 0, 16'h0004, 0);
        do_op(0, 1, 16'h0000, 0);
        total++; if (bus.read_data !== 16'h0003 || bus.count !== 4'd1) begin bad++; $display("FAIL add_pop got=%h/%0d exp=0003/1", bus.read_data, bus.count); end
        do_op(1, 1, 16'h0007, 0);
        total++; if (bus.read_data !== 16'h0007 || bus.count !== 4'd1 || bus.error !== 4'b0000) begin bad++; $display("FAIL add_rep got=%h/%0d/%b exp=0007/1/0000", bus.read_data, bus.count, bus.error); end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        do_op(1, 0, 16'h00A1, 0);
        do_op(1, 0, 16'h00B2, 0);
        do_op(0, 1, 16'h0000, 0);
        total++; if (bus.read_data !== 16'h00A1) begin bad++; $display("FAIL b2b_pop got=%h exp=00a1", bus.read_data); end
        do_op(1, 0, 16'h00C3, 0);
        do_op(0, 1, 16'h0000, 0);
        total++; if (bus.read_data !== 16'h00A1 || bus.count !== 4'd1) begin bad++; $display("FAIL b2b_final got=%h/%0d exp=00a1/1", bus.read_data, bus.count); end
    endtask

`ifdef STACK_SNAPSHOT_EN
    task automatic test_snapshot();
        pulse_reset();
        do_op(1, 0, 16'h0001, 0);
        do_op(1, 0, 16'h0002, 0);
        do_op(1, 0, 16'h0003, 0);
        total++; if (bus.snapshot !== 64'h0000_0001_0002_0003) begin bad++; $display("FAIL snapshot got=%h exp=0000000100020003", bus.snapshot); end
    endtask
`endif

    initial begin
        test_reset();
        test_push_pop();
        test_full_replace();
        test_clear_collision();
        test_async_reset();
        test_add_seq();
        test_back_to_back();
`ifdef STACK_SNAPSHOT_EN
        test_snapshot();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
